decode_pipe: RTL

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 87 ++++++++
 1 files changed

// File: rtl/decode_pipe.sv
// decode_pipe: single-stage instruction decoder with registered one-hot selects and load-use hazard detection
module decode_pipe #(
    parameter int REG_ADDR_W = 5,
    parameter int NSEL = 2 ** REG_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     ibus,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    output logic [NSEL-1:0] Aselect,
    output logic [NSEL-1:0] Bselect,
    output logic [NSEL-1:0] Dselect,
    output logic            Imm,
    output logic            Cin,
    output logic            LW,
    output logic            SW,
    output logic            BEQ,
    output logic            BNE,
    output logic [2:0]      S,
    output logic            illegal,
    output logic            out_valid,
    output logic            hazard
);
    localparam int W = 3 * NSEL + 10;
    logic [5:0] op, fn;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [NSEL-1:0] asel_n, bsel_n, dsel_n;
    logic imm_n, cin_n, lw_n, sw_n, beq_n, bne_n, ill_n, rdrt_n;
    logic [2:0] s_n;
    logic [W-1:0] word_n, q;
    logic unused_bits;
    assign unused_bits = ^ibus;
    assign op = ibus[31:26];
    assign fn = ibus[5:0];
    assign rs = ibus[21 +: REG_ADDR_W];
    assign rt = ibus[16 +: REG_ADDR_W];
    assign rd = ibus[11 +: REG_ADDR_W];
    always_comb begin
        s_n = 3'b111;
        imm_n = 1'b1;
        ill_n = 1'b1;
        cin_n = 1'b0;
        lw_n = 1'b0;
        sw_n = 1'b0;
        beq_n = 1'b0;
        bne_n = 1'b0;
        case (op)
            6'b000000: case (fn)
                6'b000011: {ill_n, imm_n, s_n} = 5'b00010;
                6'b000010: begin {ill_n, imm_n, s_n} = 5'b00011; cin_n = 1'b1; end
                6'b000001: {ill_n, imm_n, s_n} = 5'b00000;
                6'b000111: {ill_n, imm_n, s_n} = 5'b00110;
                6'b000100: {ill_n, imm_n, s_n} = 5'b00100;
                default: ;
            endcase
            6'b000011: {ill_n, s_n} = 4'b0010;
            6'b000010: begin {ill_n, s_n} = 4'b0011; cin_n = 1'b1; end
            6'b000001: {ill_n, s_n} = 4'b0000;
            6'b001111: {ill_n, s_n} = 4'b0110;
            6'b001100: {ill_n, s_n} = 4'b0100;
            6'b011110: begin {ill_n, s_n} = 4'b0010; lw_n = 1'b1; end
            6'b011111: begin {ill_n, s_n} = 4'b0010; sw_n = 1'b1; end
            6'b110000: begin {ill_n, s_n} = 4'b0010; beq_n = 1'b1; end
            6'b110001: begin {ill_n, s_n} = 4'b0010; bne_n = 1'b1; end
            default: ;
        endcase
        rdrt_n = (op == 6'b000000 && !ill_n) || sw_n || beq_n || bne_n;
    end
    assign asel_n = NSEL'(1) << rs;
    assign bsel_n = NSEL'(1) << rt;
    assign dsel_n = imm_n ? bsel_n : NSEL'(1) << rd;
    assign word_n = in_valid ? {asel_n, bsel_n, dsel_n, imm_n, cin_n, lw_n, sw_n, beq_n, bne_n, s_n, ill_n} : '0;
    assign {Aselect, Bselect, Dselect, Imm, Cin, LW, SW, BEQ, BNE, S, illegal} = q;
    // register 0 deliberately compared like any other index
    assign hazard = out_valid & LW & in_valid & (|(Dselect & (asel_n | (rdrt_n ? bsel_n : '0))));
    always_ff @(posedge clk) begin
        if (!rst_n || flush || (!stall && hazard)) begin
            q <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            q <= word_n;
            out_valid <= in_valid;
        end
    end
endmodule
